twiddle_fetch: RTL

//   Downstream consumer of twiddle_pointers. Accepts one set of per-stage twiddle

---
 rtl/twiddle_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/twiddle_fetch.sv
// Twiddle factor fetch: per-stage pointers in, Q8 twiddle factors out, with optional
// conjugation. Two registered stages (pointer capture, ROM lookup) with valid/ready on both sides.
module twiddle_fetch #(
    parameter int N               = 8,
    parameter int NUM_STAGES      = $clog2(N),
    parameter int NUM_BUTTERFLIES = N / 2,
    parameter int WIDTH           = 16,
    parameter int PTR_W           = $clog2(N / 2)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [NUM_STAGES-1:0][PTR_W-1:0]      in_ptrs_i,
    input  logic                                  in_inverse_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [NUM_STAGES-1:0][WIDTH-1:0]      tw_real_o,
    output logic [NUM_STAGES-1:0][WIDTH-1:0]      tw_imag_o
);

    // All supported sizes are subsampled from a 64-point circle; STEP is the index stride.
    localparam int STEP = 32 / NUM_BUTTERFLIES;

    // round(256*sin(2*pi*j/64)) for the first quadrant, j = 0..16
    function automatic int qsin(input int j);
        case (j)
            0:       return 0;
            1:       return 25;
            2:       return 50;
            3:       return 74;
            4:       return 98;
            5:       return 121;
            6:       return 142;
            7:       return 162;
            8:       return 181;
            9:       return 198;
            10:      return 213;
            11:      return 226;
            12:      return 237;
            13:      return 245;
            14:      return 251;
            15:      return 255;
            default: return 256;
        endcase
    endfunction

    // Upper half-plane only (angle < pi), so quadrant folding needs just two cases.
    function automatic int rom_re(input int k);
        int j = k * STEP;
        return (j <= 16) ? qsin(16 - j) : -qsin(j - 16);
    endfunction

    function automatic int rom_im(input int k);
        int j = k * STEP;
        return (j <= 16) ? -qsin(j) : -qsin(32 - j);
    endfunction

    logic                             s1_v_q, s2_v_q;
    logic [NUM_STAGES-1:0][PTR_W-1:0] s1_ptr_q;
    logic                             s1_inv_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0] tw_re_q, tw_im_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0] tw_re_d, tw_im_d;
    logic                             s1_load, s2_load;

    assign s2_load     = !s2_v_q || out_ready_i;
    assign s1_load     = !s1_v_q || s2_load;
    assign in_ready_o  = s1_load;
    assign out_valid_o = s2_v_q;
    assign tw_real_o   = tw_re_q;
    assign tw_imag_o   = tw_im_q;

    always_comb begin
        tw_re_d = '0;
        tw_im_d = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            tw_re_d[s] = WIDTH'(rom_re(int'(s1_ptr_q[s])));
            tw_im_d[s] = WIDTH'(s1_inv_q ? -rom_im(int'(s1_ptr_q[s]))
                                         :  rom_im(int'(s1_ptr_q[s])));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q   <= 1'b0;
            s1_ptr_q <= '0;
            s1_inv_q <= 1'b0;
            s2_v_q   <= 1'b0;
            tw_re_q  <= '0;
            tw_im_q  <= '0;
        end else begin
            if (s1_load) begin
                s1_v_q <= in_valid_i;
                if (in_valid_i) begin
                    s1_ptr_q <= in_ptrs_i;
                    s1_inv_q <= in_inverse_i;
                end
            end
            if (s2_load) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    tw_re_q <= tw_re_d;
                    tw_im_q <= tw_im_d;
                end
            end
        end
    end

endmodule
